// File: rtl/conv_loader.sv
// Write controller for the convolution engine's F and X vector memories.
// The first FSIZE stream words go to F and the next XSIZE words go to X; both are then held until compute_done.
module conv_loader #(
    parameter int WIDTH = 16,
    parameter int XSIZE = 64,
    parameter int LOGX  = 6,
    parameter int FSIZE = 16,
    parameter int LOGF  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] wr_data,
    output logic [LOGF-1:0]  f_addr,
    output logic             f_wr_en,
    output logic [LOGX-1:0]  x_addr,
    output logic             x_wr_en,
    output logic             load_done,
    input  logic             compute_done
);

    localparam int CW = (LOGF > LOGX) ? LOGF : LOGX;
    localparam logic [CW-1:0] F_LAST = CW'(FSIZE - 1);
    localparam logic [CW-1:0] X_LAST = CW'(XSIZE - 1);

    typedef enum logic [1:0] {
        LOAD_F,
        LOAD_X,
        FULL
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= LOAD_F;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Handshake outputs are gated with reset so nothing is accepted or written while reset is held.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        s_ready    = 1'b0;
        f_wr_en    = 1'b0;
        x_wr_en    = 1'b0;
        load_done  = 1'b0;
        case (state)
            LOAD_F: begin
                s_ready = !reset;
                f_wr_en = s_valid && !reset;
                if (s_valid) begin
                    if (cnt == F_LAST) begin
                        state_next = LOAD_X;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
            end
            LOAD_X: begin
                s_ready = !reset;
                x_wr_en = s_valid && !reset;
                if (s_valid) begin
                    if (cnt == X_LAST) begin
                        state_next = FULL;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
            end
            FULL: begin
                load_done = 1'b1;
                if (compute_done) begin
                    state_next = LOAD_F;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = LOAD_F;
                cnt_next   = '0;
            end
        endcase
    end

    assign wr_data = s_data;
    assign f_addr  = cnt[LOGF-1:0];
    assign x_addr  = cnt[LOGX-1:0];

endmodule

// File: tb/tb_conv_loader.sv
// Directed bench for conv_loader with FSIZE=4, XSIZE=8.
// Small F/X memory models capture writes so the loaded contents can be compared.
module tb_conv_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] wr_data;
    logic [1:0]  f_addr;
    logic        f_wr_en;
    logic [2:0]  x_addr;
    logic        x_wr_en;
    logic        load_done;
    logic        compute_done;

    logic [15:0] fmem [4];
    logic [15:0] xmem [8];

    int total = 0;
    int passed = 0;

    typedef struct packed {
        logic        valid;
        logic [15:0] data;
        logic        cd;
        logic        rdy;
        logic        fwe;
        logic        xwe;
        logic [1:0]  fa;
        logic [2:0]  xa;
        logic        done;
    } vec_t;

    vec_t vecs [13];

    conv_loader #(
        .WIDTH(16), .XSIZE(8), .LOGX(3), .FSIZE(4), .LOGF(2)
    ) dut (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .wr_data(wr_data), .f_addr(f_addr), .f_wr_en(f_wr_en),
        .x_addr(x_addr), .x_wr_en(x_wr_en), .load_done(load_done),
        .compute_done(compute_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (f_wr_en) fmem[f_addr] <= wr_data;
        if (x_wr_en) xmem[x_addr] <= wr_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic cd);
        @(negedge clk);
        s_valid = v;
        s_data = d;
        compute_done = cd;
        #1;
    endtask

    task automatic check_mem(input string tag, input logic [15:0] fbase, input logic [15:0] xbase);
        for (int i = 0; i < 4; i++)
            check($sformatf("%s fmem[%0d]", tag, i), 32'(fmem[i]), 32'(fbase + 16'(i)));
        for (int i = 0; i < 8; i++)
            check($sformatf("%s xmem[%0d]", tag, i), 32'(xmem[i]), 32'(xbase + 16'(i)));
    endtask

    // Streams 12 consecutive words starting at base; optional idle cycle after each word
    // and an optional compute_done pulse alongside word index cd_word.
    task automatic stream_load(input string tag, input logic [15:0] base, input bit gapped,
                               input int cd_word);
        int c;
        for (int k = 0; k < 12; k++) begin
            c = (k < 4) ? k : k - 4;
            drive(1'b1, base + 16'(k), (k == cd_word) ? 1'b1 : 1'b0);
            check($sformatf("%s w%0d s_ready", tag, k), 32'(s_ready), 32'd1);
            check($sformatf("%s w%0d f_wr_en", tag, k), 32'(f_wr_en), (k < 4) ? 32'd1 : 32'd0);
            check($sformatf("%s w%0d x_wr_en", tag, k), 32'(x_wr_en), (k >= 4) ? 32'd1 : 32'd0);
            check($sformatf("%s w%0d f_addr", tag, k), 32'(f_addr), 32'(c & 3));
            check($sformatf("%s w%0d x_addr", tag, k), 32'(x_addr), 32'(c & 7));
            check($sformatf("%s w%0d wr_data", tag, k), 32'(wr_data), 32'(base + 16'(k)));
            check($sformatf("%s w%0d load_done", tag, k), 32'(load_done), 32'd0);
            if (gapped && k < 11) begin
                c = (k + 1 < 4) ? k + 1 : k + 1 - 4;
                drive(1'b0, 16'h5555, 1'b0);
                check($sformatf("%s gap%0d f_wr_en", tag, k), 32'(f_wr_en), 32'd0);
                check($sformatf("%s gap%0d x_wr_en", tag, k), 32'(x_wr_en), 32'd0);
                check($sformatf("%s gap%0d f_addr", tag, k), 32'(f_addr), 32'(c & 3));
                check($sformatf("%s gap%0d x_addr", tag, k), 32'(x_addr), 32'(c & 7));
                check($sformatf("%s gap%0d load_done", tag, k), 32'(load_done), 32'd0);
            end
        end
        drive(1'b0, 16'h0, 1'b0);
        check($sformatf("%s end load_done", tag), 32'(load_done), 32'd1);
        check($sformatf("%s end s_ready", tag), 32'(s_ready), 32'd0);
    endtask

    initial begin
        // valid, data, cd, rdy, fwe, xwe, fa, xa, done
        vecs[0]  = '{1'b1, 16'd1,  1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0};
        vecs[1]  = '{1'b1, 16'd2,  1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 3'd1, 1'b0};
        vecs[2]  = '{1'b1, 16'd3,  1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 3'd2, 1'b0};
        vecs[3]  = '{1'b1, 16'd4,  1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 3'd3, 1'b0};
        vecs[4]  = '{1'b1, 16'd5,  1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 3'd0, 1'b0};
        vecs[5]  = '{1'b1, 16'd6,  1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 3'd1, 1'b0};
        vecs[6]  = '{1'b1, 16'd7,  1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 3'd2, 1'b0};
        vecs[7]  = '{1'b1, 16'd8,  1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 3'd3, 1'b0};
        vecs[8]  = '{1'b1, 16'd9,  1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 3'd4, 1'b0};
        vecs[9]  = '{1'b1, 16'd10, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 3'd5, 1'b0};
        vecs[10] = '{1'b1, 16'd11, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 3'd6, 1'b0};
        vecs[11] = '{1'b1, 16'd12, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 3'd7, 1'b0};
        vecs[12] = '{1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b1};

        reset = 1'b1;
        s_valid = 1'b1;
        s_data = 16'h1234;
        compute_done = 1'b0;
        #3;
        check("reset s_ready", 32'(s_ready), 32'd0);
        check("reset f_wr_en", 32'(f_wr_en), 32'd0);
        check("reset load_done", 32'(load_done), 32'd0);
        check("reset f_addr", 32'(f_addr), 32'd0);
        check("reset x_addr", 32'(x_addr), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        s_valid = 1'b0;

        // Full-rate load of words 1..12, then the first FULL cycle
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].valid, vecs[i].data, vecs[i].cd);
            check($sformatf("t1[%0d] s_ready", i), 32'(s_ready), 32'(vecs[i].rdy));
            check($sformatf("t1[%0d] f_wr_en", i), 32'(f_wr_en), 32'(vecs[i].fwe));
            check($sformatf("t1[%0d] x_wr_en", i), 32'(x_wr_en), 32'(vecs[i].xwe));
            check($sformatf("t1[%0d] f_addr", i), 32'(f_addr), 32'(vecs[i].fa));
            check($sformatf("t1[%0d] x_addr", i), 32'(x_addr), 32'(vecs[i].xa));
            check($sformatf("t1[%0d] load_done", i), 32'(load_done), 32'(vecs[i].done));
        end
        check_mem("t1", 16'd1, 16'd5);

        // FULL ignores a continuously valid stream
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 16'hFFFF, 1'b0);
            check($sformatf("hold%0d wr_en", i), 32'({f_wr_en, x_wr_en}), 32'd0);
            check($sformatf("hold%0d s_ready", i), 32'(s_ready), 32'd0);
            check($sformatf("hold%0d load_done", i), 32'(load_done), 32'd1);
        end
        check_mem("hold", 16'd1, 16'd5);

        // Release and immediately stream a second set back-to-back
        drive(1'b0, 16'h0, 1'b1);
        check("release load_done", 32'(load_done), 32'd1);
        stream_load("b2b", 16'h00A0, 1'b0, -1);
        check_mem("b2b", 16'h00A0, 16'h00A4);

        // Gapped load with a stray compute_done alongside X[3]
        drive(1'b0, 16'h0, 1'b1);
        stream_load("gap", 16'd1, 1'b1, 7);
        check_mem("gap", 16'd1, 16'd5);

        // Abort mid-load with an asynchronous reset after F[2]
        drive(1'b0, 16'h0, 1'b1);
        drive(1'b1, 16'd21, 1'b0);
        drive(1'b1, 16'd22, 1'b0);
        drive(1'b1, 16'd23, 1'b0);
        @(negedge clk);
        s_data = 16'd24;
        #2 reset = 1'b1;
        #1;
        check("async s_ready", 32'(s_ready), 32'd0);
        check("async f_wr_en", 32'(f_wr_en), 32'd0);
        check("async f_addr", 32'(f_addr), 32'd0);
        check("async load_done", 32'(load_done), 32'd0);
        @(negedge clk);
        #1;
        check("held s_ready", 32'(s_ready), 32'd0);
        check("held load_done", 32'(load_done), 32'd0);
        s_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("post-reset s_ready", 32'(s_ready), 32'd1);
        stream_load("rst", 16'd21, 1'b0, -1);
        check_mem("rst", 16'd21, 16'd25);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/conv_loader.md
# conv_loader

Input-side write controller for the convolution datapath's X and F vector memories. Accepts a valid/ready word stream, writes the first FSIZE words into the F memory and the next XSIZE words into the X memory, then holds both vectors stable until the compute engine releases them. It drives the memories' write ports (data, address, write-enable) and performs the address sequencing, fill tracking and backpressure that the memories do not.

## Interface
Parameters:
- WIDTH, 16, word width of the stream and of both memories
- XSIZE, 64, number of X words per load
- LOGX, 6, X address width; XSIZE <= 2^LOGX
- FSIZE, 16, number of F words per load
- LOGF, 4, F address width; FSIZE <= 2^LOGF

Ports:
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  asynchronous, active-high
- s_data  in  WIDTH  input stream word
- s_valid  in  1  s_data is valid this cycle
- s_ready  out  1  loader will accept a word this cycle
- wr_data  out  WIDTH  write data to both memories; equals s_data combinationally
- f_addr  out  LOGF  F memory write address
- f_wr_en  out  1  F memory write enable
- x_addr  out  LOGX  X memory write address
- x_wr_en  out  1  X memory write enable
- load_done  out  1  level; both vectors fully written and held
- compute_done  in  1  single-cycle pulse from the engine releasing the vectors

## Operation
- The FSM has three states: LOAD_F, LOAD_X and FULL. A single counter `cnt` (width max(LOGF,LOGX)) tracks the word index within the current vector.
- A word is accepted when s_valid && s_ready at a posedge.
- LOAD_F
  - s_ready=1; f_wr_en = s_valid; f_addr = cnt[LOGF-1:0]; x_wr_en=0.
  - On accept: cnt+1. If cnt==FSIZE-1, go to LOAD_X and set cnt=0.
- LOAD_X
  - s_ready=1; x_wr_en = s_valid; x_addr = cnt[LOGX-1:0]; f_wr_en=0.
  - On accept: cnt+1. If cnt==XSIZE-1, go to FULL and set cnt=0.
- FULL
  - s_ready=0; f_wr_en=0; x_wr_en=0; load_done=1.
  - On compute_done=1, go to LOAD_F with cnt=0.
- Write-enables are asserted only when a word is accepted. No write is ever issued in FULL.
- compute_done is ignored in LOAD_F and LOAD_X and has no side effects there.
- While s_valid=0 in a load state, state and cnt hold, and the addresses stay at the pending index.
- Words are written in stream order: F[0..FSIZE-1], then X[0..XSIZE-1]. No data transformation or sign handling; wr_data is a pass-through.
- f_addr and x_addr output the current cnt slice in every state. Their values are don't-care when the matching wr_en is 0, but they must be deterministic: 0 after reset.

## Timing
- Reset (asynchronous assert): state=LOAD_F, cnt=0, load_done=0.
- While reset is high, s_ready=0, f_wr_en=0 and x_wr_en=0, forced combinationally. s_ready rises in the first cycle after reset is released.
- Reset mid-load aborts the load. The next load restarts at F[0]. Memory contents are not cleared; they are overwritten by the next load.
- Write latency is zero: the memory captures wr_data at the same posedge that accepts the word.
- load_done rises in the cycle after the posedge accepting X[XSIZE-1]. At that point both memories already hold the complete vectors.
- load_done falls, and s_ready rises, in the cycle after the posedge sampling compute_done=1 in FULL.
- Minimum load time is FSIZE+XSIZE cycles at full throughput, with one word per cycle and no bubbles between the F and X phases.
- s_ready depends only on state and reset, never on s_valid. There is no combinational path from s_valid to s_ready.

## Test plan
- Reset, then stream FSIZE=4, XSIZE=8 words 1..12 with s_valid held high.
  - F mem = 1,2,3,4; X mem = 5..12.
  - load_done=1 exactly at cycle 13 after the first accept; s_ready=0 from then on.
- Same load with s_valid toggled 1,0,1,0.
  - Addresses hold during gaps; memory contents are identical to the first test.
  - No wr_en is asserted while s_valid=0.
- In FULL, hold s_valid=1 with data 0xFFFF for 10 cycles.
  - No writes occur; memories are unchanged.
  - Pulse compute_done: s_ready rises the next cycle, and the next word lands at F[0].
- Pulse compute_done during LOAD_X at word X[3].
  - It is ignored; the load completes normally with load_done after X[7].
- Assert reset asynchronously after F[2] is accepted, then release and stream 21..32.
  - F = 21..24 and X = 25..32; load_done=0 throughout reset.
- Back-to-back loads: in the cycle after compute_done, immediately stream a second 12-word set.
  - The second set fully overwrites both memories; load_done pulses low for exactly the load duration.
